sram_reader: RTL and testbench

- Read-side sequencer for the 128b x 2048 SRAM macro (sram_128b_w2048) inside corelet.
- Accepts a base address and a word count.
- Issues back-to-back read accesses on the active-low CEN/WEN/A interface, captures Q, and streams the words out over a valid/ready port into a 4-entry output buffer.
- It is the consumer counterpart of the bench/loader that writes the SRAM.

---
 rtl/sram_reader.sv | 196 +++++++++++++++++++
 tb/tb_sram_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_reader.sv
// sram_reader: read-side sequencer for the 128b x 2048 SRAM macro.
// Takes a base address and word count, issues back-to-back reads on the
// active-low CEN/WEN/A interface, captures Q one cycle after each read edge
// and streams the words out through a DEPTH-entry FIFO on a valid/ready port.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start             1-cycle request, accepted only when idle and buffer empty
//   base_addr, length first word address and word count (0..2^ADDR_W)
//   busy, done        busy from the cycle after an accepted start; done pulse
//   CEN, WEN, A       SRAM control (registered); WEN is always 1
//   Q                 SRAM read data, valid the cycle after a CEN=0 edge
//   out_data/valid    head of the output buffer / buffer non-empty
//   out_ready         downstream accept
module sram_reader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 2;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Sequencer state
  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [LEN_W-1:0]    rem_q,     rem_d;
  logic                cen_q,     cen_d;
  logic [ADDR_W-1:0]   a_q,       a_d;
  logic                rd_pend_q, rd_pend_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  // Output buffer state
  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic [DATA_W-1:0]   buf_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]    count_q,   count_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;

  logic                capture_c;
  logic                pop_c;
  logic                cen_low_c;
  logic [SUM_W-1:0]    fill_c;
  logic                room_c;

  // Slot accounting: buffered words + word landing this edge + read issued
  // last edge + the read we would issue now must fit in the buffer.
  always_comb begin
    capture_c = rd_pend_q;
    pop_c     = out_valid_q & out_ready;
    cen_low_c = !cen_q;
    fill_c    = SUM_W'(count_q) + SUM_W'(rd_pend_q) + SUM_W'(cen_low_c) + SUM_W'(1);
    room_c    = (fill_c <= SUM_W'(DEPTH));
  end

  // Sequencer next-state: the first read is issued on the accepting edge
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    cen_d     = 1'b1;
    a_d       = a_q;
    rd_pend_d = cen_low_c;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (count_q == '0)) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            cen_d   = 1'b0;
            a_d     = base_addr;
            addr_d  = base_addr + ADDR_W'(1);
            rem_d   = length - LEN_W'(1);
            busy_d  = 1'b1;
            state_d = (length == LEN_W'(1)) ? S_DRAIN : S_RUN;
          end
        end
      end

      S_RUN: begin
        if ((rem_q != '0) && room_c) begin
          cen_d  = 1'b0;
          a_d    = addr_q;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Finish once no read is outstanding; buffered words stay valid.
        if (!rd_pend_q && cen_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output FIFO next-state; capture and pop on the same edge both apply
  always_comb begin
    buf_d = buf_q;
    if (capture_c) begin
      buf_d[wr_ptr_q] = Q;
    end
    wr_ptr_d    = wr_ptr_q + PTR_W'(capture_c);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
    count_d     = count_q + CNT_W'(capture_c) - CNT_W'(pop_c);
    out_valid_d = (count_d != '0);
    // Hold the head register when empty so stale X data never appears.
    out_data_d  = out_valid_d ? buf_d[rd_ptr_d] : out_data_q;
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cen_q       <= 1'b1;
      a_q         <= '0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cen_q       <= cen_d;
      a_q         <= a_d;
      rd_pend_q   <= rd_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Buffer storage needs no reset: occupancy is tracked by count/pointers
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign CEN       = cen_q;
  assign WEN       = 1'b1;
  assign A         = a_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sram_reader.sv
// Bench for sram_reader: SRAM behavioural model, address/data scoreboard
// built from the requested base/length, and directed plus random scenarios.
module tb_sram_reader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned WORDS  = 2048;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              busy, done, CEN, WEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] sram_q = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;

  logic [DATA_W-1:0] mem [WORDS];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [DATA_W-1:0] exp_data [$];

  int n_cmp = 0;
  int n_bad = 0;
  int issued = 0;
  int popped = 0;
  int inflight = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  sram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .CEN(CEN), .WEN(WEN), .A(A), .Q(sram_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // SRAM macro: read data appears the cycle after a CEN=0 edge
  always @(posedge clk) begin
    if (!CEN) sram_q <= mem[A];
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Continuous monitor: every read address and every transferred word is
  // checked against the scoreboard; reads minus pops must never exceed DEPTH.
  always @(negedge clk) begin
    if (reset) begin
      inflight = 0;
    end else begin
      check("wen_high", DATA_W'(WEN), DATA_W'(1));
      if (!CEN) begin
        issued++;
        inflight++;
        check("read_expected", DATA_W'(exp_addr.size() != 0), DATA_W'(1));
        if (exp_addr.size() != 0) check("read_addr", DATA_W'(A), DATA_W'(exp_addr.pop_front()));
      end
      if (out_valid && out_ready) begin
        popped++;
        inflight--;
        check("word_expected", DATA_W'(exp_data.size() != 0), DATA_W'(1));
        if (exp_data.size() != 0) check("word_data", out_data, exp_data.pop_front());
      end
      check("buffer_bound", DATA_W'(inflight <= int'(DEPTH)), DATA_W'(1));
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int len, input bit accept);
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    length    = (ADDR_W+1)'(len);
    if (accept) begin
      for (int i = 0; i < len; i++) begin
        int a;
        a = (b + i) % int'(WORDS);
        exp_addr.push_back(ADDR_W'(a));
        exp_data.push_back(mem[a]);
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    check(tag, DATA_W'(seen), DATA_W'(1));
  endtask

  task automatic wait_empty(input int max_cyc, input string tag);
    bit empty;
    empty = !out_valid;
    for (int i = 0; i < max_cyc && !empty; i++) begin
      step();
      if (!out_valid) empty = 1'b1;
    end
    check(tag, DATA_W'(empty), DATA_W'(1));
  endtask

  initial begin
    int b_iss, b_pop, b_done;
    bit seen;

    for (int i = 0; i < int'(WORDS); i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

    // Reset state
    step(); step();
    check("rst_cen", DATA_W'(CEN), DATA_W'(1));
    check("rst_wen", DATA_W'(WEN), DATA_W'(1));
    check("rst_a", DATA_W'(A), DATA_W'(0));
    check("rst_busy", DATA_W'(busy), DATA_W'(0));
    check("rst_done", DATA_W'(done), DATA_W'(0));
    check("rst_valid", DATA_W'(out_valid), DATA_W'(0));
    reset = 1'b0;
    step();

    // Basic 4-word burst, cycle by cycle
    for (int i = 0; i < 4; i++) mem[5+i] = DATA_W'(i + 1);
    out_ready = 1'b1;
    b_iss = issued; b_pop = popped; b_done = done_cnt;
    do_start(5, 4, 1'b1);
    check("t0_cen", DATA_W'(CEN), DATA_W'(0));
    check("t0_a", DATA_W'(A), DATA_W'(5));
    check("t0_busy", DATA_W'(busy), DATA_W'(1));
    check("t0_valid", DATA_W'(out_valid), DATA_W'(0));
    step();
    check("t1_cen", DATA_W'(CEN), DATA_W'(0));
    check("t1_a", DATA_W'(A), DATA_W'(6));
    check("t1_valid", DATA_W'(out_valid), DATA_W'(0));
    step();
    check("t2_a", DATA_W'(A), DATA_W'(7));
    check("t2_valid", DATA_W'(out_valid), DATA_W'(1));
    check("t2_data", out_data, DATA_W'(1));
    step();
    check("t3_cen", DATA_W'(CEN), DATA_W'(0));
    check("t3_a", DATA_W'(A), DATA_W'(8));
    check("t3_data", out_data, DATA_W'(2));
    step();
    check("t4_cen", DATA_W'(CEN), DATA_W'(1));
    check("t4_data", out_data, DATA_W'(3));
    step();
    check("t5_data", out_data, DATA_W'(4));
    check("t5_done", DATA_W'(done), DATA_W'(0));
    step();
    check("t6_done", DATA_W'(done), DATA_W'(1));
    check("t6_busy", DATA_W'(busy), DATA_W'(0));
    check("t6_valid", DATA_W'(out_valid), DATA_W'(0));
    step(); step(); step();
    check("b4_reads", DATA_W'(issued - b_iss), DATA_W'(4));
    check("b4_words", DATA_W'(popped - b_pop), DATA_W'(4));
    check("b4_done_once", DATA_W'(done_cnt - b_done), DATA_W'(1));

    // Address wrap at the top of the array
    mem[2046] = DATA_W'(128'hAA); mem[2047] = DATA_W'(128'hBB); mem[0] = DATA_W'(128'hCC);
    b_iss = issued; b_pop = popped;
    do_start(2046, 3, 1'b1);
    wait_done(30, "wrap_done");
    wait_empty(30, "wrap_empty");
    check("wrap_reads", DATA_W'(issued - b_iss), DATA_W'(3));
    check("wrap_words", DATA_W'(popped - b_pop), DATA_W'(3));

    // Backpressure: only DEPTH reads while stalled, head word holds
    out_ready = 1'b0;
    b_iss = issued; b_pop = popped;
    do_start(20, 10, 1'b1);
    repeat (12) step();
    check("bp_reads", DATA_W'(issued - b_iss), DATA_W'(DEPTH));
    check("bp_cen", DATA_W'(CEN), DATA_W'(1));
    check("bp_valid", DATA_W'(out_valid), DATA_W'(1));
    check("bp_head", out_data, mem[20]);
    repeat (3) step();
    check("bp_head_hold", out_data, mem[20]);
    check("bp_busy", DATA_W'(busy), DATA_W'(1));
    out_ready = 1'b1;
    wait_done(100, "bp_done");
    wait_empty(30, "bp_empty");
    check("bp_reads_all", DATA_W'(issued - b_iss), DATA_W'(10));
    check("bp_words_all", DATA_W'(popped - b_pop), DATA_W'(10));

    // Full array with random backpressure
    for (int i = 0; i < int'(WORDS); i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_iss = issued; b_pop = popped;
    do_start(0, 2048, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (done) seen = 1'b1;
      if (seen && !out_valid) break;
    end
    out_ready = 1'b1;
    check("rnd_done", DATA_W'(seen), DATA_W'(1));
    check("rnd_empty", DATA_W'(out_valid), DATA_W'(0));
    check("rnd_reads", DATA_W'(issued - b_iss), DATA_W'(2048));
    check("rnd_words", DATA_W'(popped - b_pop), DATA_W'(2048));

    // Zero length: done next cycle, no access, never busy
    b_iss = issued; b_done = done_cnt;
    do_start(7, 0, 1'b0);
    check("z_done", DATA_W'(done), DATA_W'(1));
    check("z_busy", DATA_W'(busy), DATA_W'(0));
    check("z_cen", DATA_W'(CEN), DATA_W'(1));
    step();
    check("z_done_low", DATA_W'(done), DATA_W'(0));
    check("z_busy_low", DATA_W'(busy), DATA_W'(0));
    step();
    check("z_reads", DATA_W'(issued - b_iss), DATA_W'(0));
    check("z_done_once", DATA_W'(done_cnt - b_done), DATA_W'(1));

    // Start during a burst is ignored
    b_iss = issued; b_pop = popped; b_done = done_cnt;
    do_start(300, 6, 1'b1);
    step();
    do_start(900, 5, 1'b0);
    check("ign_busy", DATA_W'(busy), DATA_W'(1));
    wait_done(40, "ign_done");
    wait_empty(30, "ign_empty");
    repeat (3) step();
    check("ign_reads", DATA_W'(issued - b_iss), DATA_W'(6));
    check("ign_words", DATA_W'(popped - b_pop), DATA_W'(6));
    check("ign_done_once", DATA_W'(done_cnt - b_done), DATA_W'(1));

    // Reset mid-burst after three reads, then a fresh short burst
    do_start(50, 10, 1'b1);
    step(); step();
    reset = 1'b1;
    step();
    check("mr_cen", DATA_W'(CEN), DATA_W'(1));
    check("mr_valid", DATA_W'(out_valid), DATA_W'(0));
    check("mr_busy", DATA_W'(busy), DATA_W'(0));
    check("mr_done", DATA_W'(done), DATA_W'(0));
    exp_addr.delete();
    exp_data.delete();
    reset = 1'b0;
    step();
    b_iss = issued; b_pop = popped;
    do_start(100, 2, 1'b1);
    wait_done(30, "mr2_done");
    wait_empty(30, "mr2_empty");
    repeat (3) step();
    check("mr2_reads", DATA_W'(issued - b_iss), DATA_W'(2));
    check("mr2_words", DATA_W'(popped - b_pop), DATA_W'(2));
    check("mr2_sb_empty", DATA_W'(exp_data.size()), DATA_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
